// File: rtl/vmem_fill_ctrl_pkg.sv
// Shared constants for the vmem fill engine: screen geometry, register map, status bits, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vmem_fill_ctrl_pkg;

  localparam int LCD_W = 240;
  localparam int LCD_H = 240;

  // Byte offsets inside the fill-controller register window
  localparam logic [3:0] REG_XY    = 4'h0;
  localparam logic [3:0] REG_WH    = 4'h4;
  localparam logic [3:0] REG_COLOR = 4'h8;
  localparam logic [3:0] REG_CTRL  = 4'hC;

  // STATUS bit positions (read side of REG_CTRL)
  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_CLIP = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/vmem_fill_regs.sv
// Fill-engine config registers, sticky done/clipped flags and registered readback mux.
// Latency: writes take effect next cycle; rdata is valid one cycle after cfg_addr.
// Backpressure: none, every register access completes in one cycle.
// Ports: clk/rst; cfg_we/cfg_addr/cfg_wdata bus write; busy/clr_status/set_done/set_clip from the FSM;
//        x0/y0/w/h/color raw register values; start_req = CTRL write with bit0; done/clipped flags; rdata.
module vmem_fill_regs
  import vmem_fill_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_we,
  input  logic [3:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  input  logic        busy,
  input  logic        clr_status,
  input  logic        set_done,
  input  logic        set_clip,
  output logic [7:0]  x0,
  output logic [7:0]  y0,
  output logic [7:0]  w,
  output logic [7:0]  h,
  output logic [2:0]  color,
  output logic        start_req,
  output logic        done,
  output logic        clipped,
  output logic [31:0] rdata
);

  logic [31:0] rd_mux;
  // Upper data bits have no register behind them
  logic        unused_wdata;

  assign unused_wdata = ^cfg_wdata[31:16];
  assign start_req    = cfg_we && (cfg_addr == REG_CTRL) && cfg_wdata[0];

  always_comb begin
    rd_mux = '0;
    case (cfg_addr)
      REG_XY:    rd_mux[15:0] = {y0, x0};
      REG_WH:    rd_mux[15:0] = {h, w};
      REG_COLOR: rd_mux[2:0]  = color;
      REG_CTRL: begin
        rd_mux[ST_BUSY] = busy;
        rd_mux[ST_DONE] = done;
        rd_mux[ST_CLIP] = clipped;
      end
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x0      <= '0;
      y0      <= '0;
      w       <= '0;
      h       <= '0;
      color   <= '0;
      done    <= 1'b0;
      clipped <= 1'b0;
      rdata   <= '0;
    end else begin
      if (cfg_we) begin
        case (cfg_addr)
          REG_XY:    {y0, x0} <= cfg_wdata[15:0];
          REG_WH:    {h, w}   <= cfg_wdata[15:0];
          REG_COLOR: color    <= cfg_wdata[2:0];
          default:   ;
        endcase
      end
      // Clear and set never coincide: clear only happens in IDLE, set only outside it
      if (clr_status) begin
        done    <= 1'b0;
        clipped <= 1'b0;
      end
      if (set_done) done    <= 1'b1;
      if (set_clip) clipped <= 1'b1;
      rdata <= rd_mux;
    end
  end

endmodule

// File: rtl/vmem_fill_ctrl.sv
// Rectangle-fill engine and vmem write arbiter; CPU pixel writes win over engine pixels.
// Latency: CPU write -> vmem 1 cycle; start write -> first engine pixel on vmem 3 cycles.
// Backpressure: a CPU write stalls the scan for that cycle; no engine pixel is dropped.
// Ports: clk_i/rst_i; cfg_* register bus with registered cfg_rdata_o; cpu_* pixel writes;
//        vmem_* registered write port {y,x} address; busy_o high outside IDLE.
module vmem_fill_ctrl #(
  parameter int LCD_W = 240,
  parameter int LCD_H = 240
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cfg_we_i,
  input  logic [3:0]  cfg_addr_i,
  input  logic [31:0] cfg_wdata_i,
  output logic [31:0] cfg_rdata_o,
  input  logic        cpu_we_i,
  input  logic [15:0] cpu_addr_i,
  input  logic [2:0]  cpu_wdata_i,
  output logic        vmem_we_o,
  output logic [15:0] vmem_addr_o,
  output logic [2:0]  vmem_wdata_o,
  output logic        busy_o
);
  import vmem_fill_ctrl_pkg::*;

  state_t      state, state_nxt;
  logic [7:0]  x0, y0, w, h;
  logic [2:0]  color;
  logic        start_req, done, clipped;
  logic        start_acc, issue, set_done, set_clip;

  // Working copies latched in LOAD, so register writes during a fill only affect the next one
  logic [7:0]  wx0, wx_end, wy_end, cx, cy;
  logic [2:0]  wcolor;

  logic [8:0]  room_w, room_h;
  logic        over_w, over_h, empty;
  logic [7:0]  w_eff, h_eff, x_end, y_end;

  assign busy_o = (state != S_IDLE);

  vmem_fill_regs u_regs (
    .clk        (clk_i),
    .rst        (rst_i),
    .cfg_we     (cfg_we_i),
    .cfg_addr   (cfg_addr_i),
    .cfg_wdata  (cfg_wdata_i),
    .busy       (busy_o),
    .clr_status (start_acc),
    .set_done   (set_done),
    .set_clip   (set_clip),
    .x0         (x0),
    .y0         (y0),
    .w          (w),
    .h          (h),
    .color      (color),
    .start_req  (start_req),
    .done       (done),
    .clipped    (clipped),
    .rdata      (cfg_rdata_o)
  );

  // Clipping. room_* goes negative (bit 8 set) when the origin is past the edge
  // and is zero when it sits exactly on it; both mean an empty rectangle.
  always_comb begin
    room_w = 9'(LCD_W) - {1'b0, x0};
    room_h = 9'(LCD_H) - {1'b0, y0};
    empty  = room_w[8] || (room_w == 9'd0) || room_h[8] || (room_h == 9'd0) ||
             (w == 8'd0) || (h == 8'd0);
    over_w = ({1'b0, w} > room_w);
    over_h = ({1'b0, h} > room_h);
    // Only meaningful when not empty, where room_* <= 240 fits in 8 bits
    w_eff  = over_w ? room_w[7:0] : w;
    h_eff  = over_h ? room_h[7:0] : h;
    x_end  = x0 + w_eff - 8'd1;
    y_end  = y0 + h_eff - 8'd1;
  end

  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    issue     = 1'b0;
    set_done  = 1'b0;
    set_clip  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_req) begin
          start_acc = 1'b1;
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (empty) begin
          set_done  = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          set_clip  = over_w || over_h;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (!cpu_we_i) begin
          issue = 1'b1;
          if ((cx == wx_end) && (cy == wy_end)) begin
            set_done  = 1'b1;
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= S_IDLE;
      wx0          <= '0;
      wx_end       <= '0;
      wy_end       <= '0;
      cx           <= '0;
      cy           <= '0;
      wcolor       <= '0;
      vmem_we_o    <= 1'b0;
      vmem_addr_o  <= '0;
      vmem_wdata_o <= '0;
    end else begin
      state <= state_nxt;

      if (state == S_LOAD) begin
        wx0    <= x0;
        wx_end <= x_end;
        wy_end <= y_end;
        cx     <= x0;
        cy     <= y0;
        wcolor <= color;
      end else if (issue) begin
        // Row wrap is folded into the same cycle, so there is no bubble between rows
        if (cx == wx_end) begin
          cx <= wx0;
          cy <= cy + 8'd1;
        end else begin
          cx <= cx + 8'd1;
        end
      end

      if (cpu_we_i) begin
        vmem_we_o    <= 1'b1;
        vmem_addr_o  <= cpu_addr_i;
        vmem_wdata_o <= cpu_wdata_i;
      end else if (issue) begin
        vmem_we_o    <= 1'b1;
        vmem_addr_o  <= {cy, cx};
        vmem_wdata_o <= wcolor;
      end else begin
        vmem_we_o    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vmem_fill_ctrl.sv
module tb_vmem_fill_ctrl;

  localparam int LCD_W = 240;
  localparam int LCD_H = 240;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        cfg_we_i = 1'b0;
  logic [3:0]  cfg_addr_i = 4'h0;
  logic [31:0] cfg_wdata_i = 32'h0;
  logic [31:0] cfg_rdata_o;
  logic        cpu_we_i = 1'b0;
  logic [15:0] cpu_addr_i = 16'h0;
  logic [2:0]  cpu_wdata_i = 3'h0;
  logic        vmem_we_o;
  logic [15:0] vmem_addr_o;
  logic [2:0]  vmem_wdata_o;
  logic        busy_o;

  vmem_fill_ctrl #(.LCD_W(LCD_W), .LCD_H(LCD_H)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .cfg_we_i     (cfg_we_i),
    .cfg_addr_i   (cfg_addr_i),
    .cfg_wdata_i  (cfg_wdata_i),
    .cfg_rdata_o  (cfg_rdata_o),
    .cpu_we_i     (cpu_we_i),
    .cpu_addr_i   (cpu_addr_i),
    .cpu_wdata_i  (cpu_wdata_i),
    .vmem_we_o    (vmem_we_o),
    .vmem_addr_o  (vmem_addr_o),
    .vmem_wdata_o (vmem_wdata_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_err = 0;
  int n_chk = 0;

  // Observations of the latest do_fill run
  int obs_n, obs_first, obs_last, busy_n;

  typedef struct {
    int x0, y0, w, h, col;
    int n, first, last;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic cfg_wr(input logic [3:0] a, input logic [31:0] d);
    cfg_we_i    = 1'b1;
    cfg_addr_i  = a;
    cfg_wdata_i = d;
    step();
    cfg_we_i    = 1'b0;
    cfg_wdata_i = 32'h0;
  endtask

  task automatic cfg_rd(input logic [3:0] a, output logic [31:0] d);
    cfg_addr_i = a;
    step();
    d = cfg_rdata_o;
  endtask

  // Programs a rectangle, starts it, and checks every cycle against a reference:
  // the expected pixel list comes from the clipping rules, and in each cycle from
  // two cycles after the start write the engine emits the next pixel unless the
  // CPU writes. force_cpu bit k forces a CPU write (to 0x0505) in cycle k.
  task automatic do_fill(input int x0, input int y0, input int w, input int h, input int col,
                         input int pct, input logic [63:0] force_cpu);
    int          px[$];
    int          we_x, he_y;
    bit          emp, exp_clip, cpu, frc;
    logic        e_we;
    logic [15:0] e_a;
    logic [2:0]  e_d;
    logic [31:0] st;
    emp      = (x0 >= LCD_W) || (y0 >= LCD_H) || (w == 0) || (h == 0);
    exp_clip = 1'b0;
    if (!emp) begin
      we_x     = (w < LCD_W - x0) ? w : LCD_W - x0;
      he_y     = (h < LCD_H - y0) ? h : LCD_H - y0;
      exp_clip = (we_x != w) || (he_y != h);
      for (int yy = y0; yy < y0 + he_y; yy++)
        for (int xx = x0; xx < x0 + we_x; xx++)
          px.push_back(yy * 256 + xx);
    end
    obs_n = 0; obs_first = -1; obs_last = -1; busy_n = 0;
    cfg_wr(4'h0, 32'((y0 << 8) | x0));
    cfg_wr(4'h4, 32'((h << 8) | w));
    cfg_wr(4'h8, 32'(col));
    cfg_we_i    = 1'b1;
    cfg_addr_i  = 4'hC;
    cfg_wdata_i = 32'h1;
    for (int k = 0; k < 4000; k++) begin
      frc = (k < 64) ? force_cpu[k] : 1'b0;
      cpu = frc || ($urandom_range(99) < 32'(pct));
      cpu_we_i    = cpu;
      cpu_addr_i  = frc ? 16'h0505 : 16'($urandom);
      cpu_wdata_i = 3'($urandom);
      e_a = 16'h0; e_d = 3'h0;
      if (cpu) begin
        e_we = 1'b1; e_a = cpu_addr_i; e_d = cpu_wdata_i;
      end else if (k >= 2 && px.size() > 0) begin
        e_we = 1'b1; e_a = 16'(px.pop_front()); e_d = 3'(col);
      end else begin
        e_we = 1'b0;
      end
      step();
      cfg_we_i = 1'b0; cfg_wdata_i = 32'h0; cpu_we_i = 1'b0;
      chk("vmem_we", {31'b0, vmem_we_o}, {31'b0, e_we});
      if (e_we) begin
        chk("vmem_addr", {16'b0, vmem_addr_o}, {16'b0, e_a});
        chk("vmem_wdata", {29'b0, vmem_wdata_o}, {29'b0, e_d});
      end
      chk("busy", {31'b0, busy_o}, {31'b0, (k == 0) || (px.size() > 0)});
      if (vmem_we_o) begin
        obs_n++;
        if (obs_first < 0) obs_first = int'(vmem_addr_o);
        obs_last = int'(vmem_addr_o);
      end
      if (busy_o) busy_n++;
      if (k >= 1 && px.size() == 0) break;
    end
    chk("fill_finished", px.size(), 0);
    cfg_rd(4'hC, st);
    chk("status", st, {29'b0, exp_clip, 1'b1, 1'b0});
  endtask

  initial begin
    logic [31:0] rd;
    int cnt, bad;

    vt[0] = '{10, 20, 3, 2, 5, 6, 'h140A, 'h150C};
    vt[1] = '{238, 239, 10, 10, 3, 2, 'hEFEE, 'hEFEF};
    vt[2] = '{5, 5, 0, 4, 1, 0, -1, -1};
    vt[3] = '{240, 0, 5, 5, 2, 0, -1, -1};
    vt[4] = '{239, 239, 1, 1, 7, 1, 'hEFEF, 'hEFEF};
    vt[5] = '{0, 0, 4, 1, 6, 4, 'h0000, 'h0003};
    vt[6] = '{230, 0, 20, 3, 4, 30, 'h00E6, 'h02EF};

    // Reset state
    rst_i = 1'b1;
    step(); step();
    chk("rst_vmem_we", {31'b0, vmem_we_o}, 0);
    chk("rst_vmem_addr", {16'b0, vmem_addr_o}, 0);
    chk("rst_vmem_wdata", {29'b0, vmem_wdata_o}, 0);
    chk("rst_busy", {31'b0, busy_o}, 0);
    chk("rst_rdata", cfg_rdata_o, 0);
    rst_i = 1'b0;
    step();

    // CPU write path while idle
    cpu_we_i = 1'b1; cpu_addr_i = 16'h1111; cpu_wdata_i = 3'd6;
    step();
    cpu_we_i = 1'b0;
    chk("cpu_idle_we", {31'b0, vmem_we_o}, 1);
    chk("cpu_idle_addr", {16'b0, vmem_addr_o}, 32'h1111);
    chk("cpu_idle_wdata", {29'b0, vmem_wdata_o}, 6);
    step();
    chk("cpu_idle_we_off", {31'b0, vmem_we_o}, 0);

    // Register readback
    cfg_wr(4'h0, 32'hDEAD1234);
    cfg_wr(4'h4, 32'h0000ABCD);
    cfg_wr(4'h8, 32'h000000FF);
    cfg_rd(4'h0, rd); chk("rd_xy", rd, 32'h1234);
    cfg_rd(4'h4, rd); chk("rd_wh", rd, 32'hABCD);
    cfg_rd(4'h8, rd); chk("rd_color", rd, 32'h7);
    cfg_rd(4'hC, rd); chk("rd_status_idle", rd, 32'h0);
    cfg_rd(4'h2, rd); chk("rd_unmapped", rd, 32'h0);

    // Directed rectangles
    for (int i = 0; i < 7; i++) begin
      do_fill(vt[i].x0, vt[i].y0, vt[i].w, vt[i].h, vt[i].col, 0, 64'h0);
      chk($sformatf("vec%0d_count", i), obs_n, vt[i].n);
      chk($sformatf("vec%0d_first", i), obs_first, vt[i].first);
      chk($sformatf("vec%0d_last", i), obs_last, vt[i].last);
    end

    // Contention: two CPU writes in the middle of a 4x1 fill
    do_fill(0, 0, 4, 1, 2, 0, 64'h18);
    chk("contend_writes", obs_n, 6);
    chk("contend_busy_cycles", busy_n, 7);

    // Random rectangles near the edges with random CPU traffic
    for (int i = 0; i < 12; i++)
      do_fill(int'($urandom_range(200, 255)), int'($urandom_range(225, 255)),
              int'($urandom_range(0, 20)), int'($urandom_range(0, 4)),
              int'($urandom_range(0, 7)), 30, 64'h0);

    // Full screen; an XY rewrite and a second start mid-fill must not disturb it
    cfg_wr(4'h0, 32'h0);
    cfg_wr(4'h4, 32'hF0F0);
    cfg_wr(4'h8, 32'h3);
    cfg_we_i = 1'b1; cfg_addr_i = 4'hC; cfg_wdata_i = 32'h1;
    cnt = 0; bad = 0;
    for (int k = 0; k < 60000; k++) begin
      if (k == 50) begin cfg_we_i = 1'b1; cfg_addr_i = 4'h0; cfg_wdata_i = 32'h0A0A; end
      if (k == 51) begin cfg_we_i = 1'b1; cfg_addr_i = 4'hC; cfg_wdata_i = 32'h1; end
      step();
      cfg_we_i = 1'b0; cfg_wdata_i = 32'h0;
      if (vmem_we_o) begin
        if (int'(vmem_addr_o) != (((cnt / LCD_W) << 8) | (cnt % LCD_W))) bad++;
        if (vmem_wdata_o != 3'd3) bad++;
        cnt++;
      end
      if (k >= 1 && !busy_o) break;
    end
    chk("full_count", cnt, 57600);
    chk("full_order", bad, 0);
    cnt = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (busy_o || vmem_we_o) cnt++;
    end
    chk("full_no_restart", cnt, 0);
    cfg_rd(4'hC, rd); chk("full_status", rd, 32'h2);
    cfg_rd(4'h0, rd); chk("full_xy_kept", rd, 32'h0A0A);

    // Reset in the middle of a fill
    cfg_wr(4'h0, 32'h0);
    cfg_wr(4'h4, 32'h1414);
    cfg_we_i = 1'b1; cfg_addr_i = 4'hC; cfg_wdata_i = 32'h1;
    cnt = 0;
    for (int k = 0; k < 400; k++) begin
      step();
      cfg_we_i = 1'b0; cfg_wdata_i = 32'h0;
      if (vmem_we_o) cnt++;
      if (cnt == 100) break;
    end
    chk("rstmid_reached", cnt, 100);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk("rstmid_we", {31'b0, vmem_we_o}, 0);
    chk("rstmid_busy", {31'b0, busy_o}, 0);
    chk("rstmid_rdata", cfg_rdata_o, 0);
    cfg_rd(4'hC, rd); chk("rstmid_status", rd, 0);
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (vmem_we_o || busy_o) cnt++;
    end
    chk("rstmid_quiet", cnt, 0);
    cfg_rd(4'h4, rd); chk("rstmid_wh", rd, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/vmem_fill_ctrl.md
# vmem_fill_ctrl

Rectangle-fill engine and write arbiter for the 240x240, 3-bit-per-pixel video memory. It sits between the CPU data bus and the vmem write port. It owns four memory-mapped config/status registers and, once started, writes one pixel per cycle into vmem. CPU pixel writes always take priority and stall the engine, so software can draw while a hardware fill runs.

## Interface
Parameters:
- LCD_W, 240, screen width in pixels (x range 0..LCD_W-1).
- LCD_H, 240, screen height in pixels (y range 0..LCD_H-1).

Ports:
- clk_i  in  1  system clock; single clock domain.
- rst_i  in  1  reset; synchronous, active-high.
- cfg_we_i  in  1  register write strobe (dbus write to the fill-controller region).
- cfg_addr_i  in  4  byte offset: 0x0 XY, 0x4 WH, 0x8 COLOR, 0xC CTRL/STATUS.
- cfg_wdata_i  in  32  register write data.
- cfg_rdata_o  out  32  registered read data for cfg_addr_i of the previous cycle.
- cpu_we_i  in  1  CPU pixel write strobe.
- cpu_addr_i  in  16  CPU pixel address {y[7:0], x[7:0]}.
- cpu_wdata_i  in  3  CPU pixel colour {R,G,B}.
- vmem_we_o  out  1  vmem write strobe (registered).
- vmem_addr_o  out  16  vmem address {y, x} (registered).
- vmem_wdata_o  out  3  vmem colour (registered).
- busy_o  out  1  high while the state is not IDLE.

## Operation
- Registers:
  - XY: x0 = [7:0], y0 = [15:8].
  - WH: w = [7:0], h = [15:8].
  - COLOR: [2:0].
  - CTRL write: bit0 = 1 means start.
  - STATUS read: bit0 busy, bit1 done (sticky), bit2 clipped (sticky); other bits read 0.
  - XY, WH and COLOR read back as written; unused bits read 0.
- XY, WH and COLOR may be written at any time. The engine copies them into working registers only in the LOAD state, so a write during a fill affects the next fill only.
- Start while busy is ignored. Start while idle clears done and clipped, then enters LOAD.
- State machine:
  - IDLE -> LOAD on an accepted start.
  - LOAD computes clipped extents and goes to RUN, or back to IDLE if the rectangle is empty.
  - RUN -> IDLE after the last pixel is issued.
- Clipping, computed in LOAD:
  - If x0 >= LCD_W, y0 >= LCD_H, w == 0 or h == 0, the rectangle is empty: no writes, done = 1.
  - Otherwise w_eff = min(w, LCD_W - x0) and h_eff = min(h, LCD_H - y0). Use 9-bit subtraction.
  - clipped = 1 if either extent was reduced.
  - x_end = x0 + w_eff - 1 and y_end = y0 + h_eff - 1; both fit in 8 bits.
- RUN scan order is raster (x inner, y outer), starting at (x0, y0).
  - On a cycle with cpu_we_i = 0: issue pixel (cx, cy). If cx == x_end then cx <= x0 and cy <= cy + 1; otherwise cx <= cx + 1.
  - When (cx, cy) == (x_end, y_end) is issued: go to IDLE and set done = 1.
  - On a cycle with cpu_we_i = 1: the CPU write is issued, the engine holds position, and no pixel is lost.
- Output mux, registered: vmem_* take the CPU write if cpu_we_i = 1, else the engine pixel if in RUN, else vmem_we_o = 0.
- Reset: IDLE; all registers, working copies, done, clipped, cfg_rdata_o, vmem_we_o, vmem_addr_o, vmem_wdata_o and busy_o are 0.
- Reset mid-fill aborts the fill and drops any pending registered write.

## Timing
- CPU write path: cpu_we_i in cycle N appears on vmem_we_o in cycle N+1, in every state.
- Start path:
  - Start write accepted at edge E0; busy_o = 1 from the cycle after E0.
  - LOAD occupies one cycle; the first engine pixel is on vmem_we_o 3 cycles after the start write cycle.
- Throughput: with no CPU contention, a fill of w_eff*h_eff pixels issues one pixel per cycle, back-to-back with no row-change bubble.
- Completion: the last engine vmem write is visible in the same cycle that busy_o = 0 and STATUS.done = 1.
- An empty rectangle returns busy_o to 0 two cycles after the start write, with no writes.
- Register reads: cfg_rdata_o is valid one cycle after cfg_addr_i is presented.
- Simultaneous CTRL start and XY/WH write in the same cycle cannot occur (single address). A start is always followed by at least one cycle before LOAD samples the registers.

## Structure
- Shared package/header: LCD_W, LCD_H, register offsets (REG_XY, REG_WH, REG_COLOR, REG_CTRL), STATUS bit positions, and state encoding (S_IDLE, S_LOAD, S_RUN).
- One sub-module is natural: vmem_fill_regs (register file, readback mux, done/clipped sticky bits).
- The FSM, scan counters and output mux stay in vmem_fill_ctrl.

## Test plan
- Inside fill: x0 = 10, y0 = 20, w = 3, h = 2, colour 5, start -> exactly 6 writes, addrs 0x140A, 0x140B, 0x140C, 0x150A, 0x150B, 0x150C, data 5; done = 1; clipped = 0.
- Clipped fill: x0 = 238, y0 = 239, w = 10, h = 10 -> exactly 2 writes, 0xEFEE and 0xEFEF; clipped = 1.
- Contention: during a 4x1 fill at (0, 0), assert cpu_we_i to 0x0505 for 2 cycles mid-run -> both CPU writes appear next cycle; all 4 engine pixels still written; total 6 writes; busy is 2 cycles longer.
- Empty fill and start-while-busy: w = 0 start -> no writes, done in 2 cycles. During a 240x240 fill, rewrite XY and start -> ignored; 57600 writes with the original geometry.
- Reset mid-fill: assert rst_i after 100 pixels -> next cycle vmem_we_o = 0, busy_o = 0, STATUS = 0; no further writes.
- Readback: write XY = 0x1234, WH = 0xABCD, COLOR = 0xFF -> reads return 0x1234, 0xABCD, 0x7 one cycle after address.
